data_memory_lsu: RTL

//  Parametrised data memory with a load/store front end for the single-cycle/multi-cycle RISC-V core.

---
 rtl/data_memory_lsu.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/data_memory_lsu.sv
// Data memory with a RISC-V load/store front end: sized accesses, byte-lane
// writes, fixed wait states, req/ready/done handshake and fault reporting.

// One byte lane of the word array; zero at time 0, never cleared by reset.
module dmem_lane #(
  parameter int DEPTH = 64,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [7:0]    wd,
  output logic [7:0]    rd
);
  logic [7:0] mem [DEPTH] = '{default: 8'h00};

  // byte write on the commit edge
  always_ff @(posedge clk)
    if (we) mem[idx] <= wd;

  assign rd = mem[idx];
endmodule

module data_memory_lsu #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  ready,
  output logic                  done,
  output logic                  fault,
  output logic [31:0]           rdata
);
  localparam int IW = $clog2(DEPTH_WORDS);

  typedef struct packed {
    logic                  we;
    logic [2:0]            f3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t          state, state_nx;
  req_t            rq, cur;
  logic [3:0]      cnt;
  logic            accept, flt, wr_en;
  logic [IW-1:0]   idx;
  logic [1:0]      sub;
  logic [15:0]     half;
  logic [31:0]     ld;
  logic [3:0]      be;
  logic [3:0][7:0] rword, wword;

  assign accept = req && ready;
  assign ready  = (state == S_IDLE) && !rst;
  assign done   = (state == S_ACCESS);
  assign fault  = done && flt;

  // With zero wait states the load result is captured on the accept edge,
  // before the request register is loaded, so decode the live inputs in IDLE.
  assign cur = (state == S_IDLE) ? '{we: we, f3: funct3, addr: addr, wdata: wdata} : rq;
  assign idx = cur.addr[IW+1:2];
  assign sub = cur.addr[1:0];

  // fault decode: illegal funct3, misalignment, address beyond the array
  always_comb begin
    flt = 1'b0;
    if (cur.we) flt = (cur.f3 > 3'b010);
    else        flt = (cur.f3 == 3'b011) || (cur.f3[2:1] == 2'b11);
    if (cur.f3[1:0] == 2'b01 && sub[0])         flt = 1'b1;
    if (cur.f3[1:0] == 2'b10 && sub != 2'b00)   flt = 1'b1;
    if (|cur.addr[ADDR_WIDTH-1:IW+2])           flt = 1'b1;
  end

  // store lane enables and lane-replicated write data
  always_comb begin
    be    = 4'b1111;
    wword = cur.wdata;
    case (cur.f3[1:0])
      2'b00: begin be = 4'b0001 << sub; wword = {4{cur.wdata[7:0]}}; end
      2'b01: begin be = sub[1] ? 4'b1100 : 4'b0011; wword = {2{cur.wdata[15:0]}}; end
      default: ;
    endcase
  end

  assign wr_en = (state == S_ACCESS) && rq.we && !flt && !rst;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_lane
      dmem_lane #(.DEPTH(DEPTH_WORDS)) u_lane (
        .clk (clk),
        .we  (wr_en && be[g]),
        .idx (idx),
        .wd  (wword[g]),
        .rd  (rword[g])
      );
    end
  endgenerate

  // load extract and sign/zero extension
  always_comb begin
    half = cur.addr[1] ? rword[3:2] : rword[1:0];
    case (cur.f3)
      3'b000:  ld = {{24{rword[sub][7]}}, rword[sub]};
      3'b001:  ld = {{16{half[15]}}, half};
      3'b100:  ld = {24'h0, rword[sub]};
      3'b101:  ld = {16'h0, half};
      default: ld = rword;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_nx;

  // next state: IDLE -> WAIT (skipped when no wait states) -> ACCESS -> IDLE
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (cnt == 4'd1) state_nx = S_ACCESS;
      S_ACCESS: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // request latch and wait-state counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rq  <= '0;
      cnt <= '0;
    end else if (accept) begin
      rq  <= cur;
      cnt <= 4'(WAIT_STATES);
    end else if (state == S_WAIT) begin
      cnt <= cnt - 4'd1;
    end

  // load result captured on the edge entering ACCESS; stores/faults leave it
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (state != S_ACCESS && state_nx == S_ACCESS && !cur.we && !flt)
      rdata <= ld;
endmodule
